// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - tick-driven move sequencer with buffered turn and wall-query handshake
module move_sequencer #(
    parameter int PEND_TICKS = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       tick,
    output logic       query_req,
    output logic [1:0] query_dir,
    input  logic       query_ack,
    input  logic       query_blocked,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       cur_valid,
    output logic [1:0] cur_dir,
    output logic       pend_valid,
    output logic [1:0] pend_dir,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, ASK_PEND, ASK_CUR, MOVE} state_t;

    localparam logic [7:0] PEND_INIT = 8'(PEND_TICKS);

    state_t     state;
    logic [7:0] expiry;
    logic       press_seen;
    logic       any_press;
    logic [1:0] press_dir;

    assign any_press = up | down | left | right;

    always_comb begin
        press_dir = 2'b11;
        if (up)
            press_dir = 2'b00;
        else if (down)
            press_dir = 2'b01;
        else if (left)
            press_dir = 2'b10;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            query_req  <= 1'b0;
            query_dir  <= 2'b00;
            move_valid <= 1'b0;
            move_dir   <= 2'b00;
            cur_valid  <= 1'b0;
            cur_dir    <= 2'b00;
            pend_valid <= 1'b0;
            pend_dir   <= 2'b00;
            overrun    <= 1'b0;
            expiry     <= 8'd0;
            press_seen <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            overrun    <= tick && (state != IDLE);

            case (state)
                IDLE: begin
                    if (tick) begin
                        if (pend_valid) begin
                            state      <= ASK_PEND;
                            query_req  <= 1'b1;
                            query_dir  <= pend_dir;
                            press_seen <= any_press;
                        end else if (cur_valid) begin
                            state     <= ASK_CUR;
                            query_req <= 1'b1;
                            query_dir <= cur_dir;
                        end
                    end
                end
                ASK_PEND: begin
                    if (any_press)
                        press_seen <= 1'b1;
                    if (query_ack) begin
                        if (!query_blocked) begin
                            state     <= MOVE;
                            query_req <= 1'b0;
                            cur_dir   <= query_dir;
                            cur_valid <= 1'b1;
                            if (!press_seen)
                                pend_valid <= 1'b0;
                        end else begin
                            // Counter sits at >=1 while pend is live, so reaching 0 means expiry.
                            if (expiry != 8'd0)
                                expiry <= expiry - 8'd1;
                            if (expiry <= 8'd1)
                                pend_valid <= 1'b0;
                            if (cur_valid) begin
                                state     <= ASK_CUR;
                                query_dir <= cur_dir;
                            end else begin
                                state     <= IDLE;
                                query_req <= 1'b0;
                            end
                        end
                    end
                end
                ASK_CUR: begin
                    if (query_ack) begin
                        query_req <= 1'b0;
                        state     <= query_blocked ? IDLE : MOVE;
                    end
                end
                MOVE: begin
                    move_valid <= 1'b1;
                    move_dir   <= query_dir;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A fresh press always wins over any clear/decrement made above.
            if (any_press) begin
                pend_valid <= 1'b1;
                pend_dir   <= press_dir;
                expiry     <= PEND_INIT;
            end
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed self-checking bench for move_sequencer
module tb_move_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       tick = 1'b0;
    logic       query_req;
    logic [1:0] query_dir;
    logic       query_ack;
    logic       query_blocked;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       cur_valid;
    logic [1:0] cur_dir;
    logic       pend_valid;
    logic [1:0] pend_dir;
    logic       overrun;

    logic       ack_en = 1'b1;
    logic [3:0] walls = 4'b0000;

    int errors = 0;
    int checks = 0;

    // Maze responder: walls indexed by direction code, acks immediately when enabled.
    assign query_ack     = ack_en & query_req;
    assign query_blocked = walls[query_dir];

    always #10 CLOCK_50 = ~CLOCK_50;

    move_sequencer #(.PEND_TICKS(8)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .tick         (tick),
        .query_req    (query_req),
        .query_dir    (query_dir),
        .query_ack    (query_ack),
        .query_blocked(query_blocked),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .cur_valid    (cur_valid),
        .cur_dir      (cur_dir),
        .pend_valid   (pend_valid),
        .pend_dir     (pend_dir),
        .overrun      (overrun)
    );

    task automatic press(input logic [3:0] k);
        {up, down, left, right} = k;
        @(negedge CLOCK_50);
        {up, down, left, right} = 4'b0000;
    endtask

    task automatic do_tick(output int lat, output int nmv, output logic [1:0] mdir,
                           output int nq, output logic [1:0] qd0);
        lat = 0; nmv = 0; mdir = 2'b00; nq = 0; qd0 = 2'b00;
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (query_req) begin
                if (nq == 0) qd0 = query_dir;
                nq++;
            end
            if (move_valid) begin
                if (nmv == 0) begin
                    lat  = i;
                    mdir = move_dir;
                end
                nmv++;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        right = 1'b1;
        @(negedge CLOCK_50);
        right = 1'b0;
        reset = 1'b0;
        checks++; if (query_req !== 1'b0) begin errors++; $display("FAIL reset_query_req got %b exp 0", query_req); end
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_move_valid got %b exp 0", move_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (cur_valid !== 1'b0) begin errors++; $display("FAIL reset_cur_valid got %b exp 0", cur_valid); end
        checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend_valid got %b exp 0", pend_valid); end
        checks++; if ({cur_dir, pend_dir, move_dir, query_dir} !== 8'h00) begin errors++; $display("FAIL reset_dirs got %h exp 00", {cur_dir, pend_dir, move_dir, query_dir}); end
    endtask

    task automatic test_first_move;
        int lat, nmv, nq;
        logic [1:0] mdir, qd0;
        walls = 4'b0000; ack_en = 1'b1;
        press(4'b0001);
        checks++; if ({pend_valid, pend_dir} !== 3'b111) begin errors++; $display("FAIL capture_right got %b exp 111", {pend_valid, pend_dir}); end
        do_tick(lat, nmv, mdir, nq, qd0);
        checks++; if (lat !== 3) begin errors++; $display("FAIL first_latency got %0d exp 3", lat); end
        checks++; if (nmv !== 1 || mdir !== 2'b11) begin errors++; $display("FAIL first_move got n=%0d dir=%b exp n=1 dir=11", nmv, mdir); end
        checks++; if (nq !== 1 || qd0 !== 2'b11) begin errors++; $display("FAIL first_query got n=%0d dir=%b exp n=1 dir=11", nq, qd0); end
        checks++; if ({cur_valid, cur_dir, pend_valid} !== 4'b1110) begin errors++; $display("FAIL first_regs got %b exp 1110", {cur_valid, cur_dir, pend_valid}); end
    endtask

    task automatic test_turn_retry;
        int lat, nmv, nq;
        logic [1:0] mdir, qd0;
        press(4'b1000);
        walls = 4'b0001;
        for (int t = 0; t < 2; t++) begin
            do_tick(lat, nmv, mdir, nq, qd0);
            checks++; if (lat !== 4 || mdir !== 2'b11 || nmv !== 1) begin errors++; $display("FAIL retry_move%0d got lat=%0d dir=%b n=%0d exp lat=4 dir=11 n=1", t, lat, mdir, nmv); end
            checks++; if (nq !== 2 || qd0 !== 2'b00) begin errors++; $display("FAIL retry_query%0d got n=%0d dir=%b exp n=2 dir=00", t, nq, qd0); end
            checks++; if ({pend_valid, pend_dir} !== 3'b100) begin errors++; $display("FAIL retry_pend%0d got %b exp 100", t, {pend_valid, pend_dir}); end
        end
        walls = 4'b0000;
        do_tick(lat, nmv, mdir, nq, qd0);
        checks++; if (lat !== 3 || mdir !== 2'b00) begin errors++; $display("FAIL turn_move got lat=%0d dir=%b exp lat=3 dir=00", lat, mdir); end
        checks++; if ({cur_dir, pend_valid} !== 3'b000) begin errors++; $display("FAIL turn_regs got %b exp 000", {cur_dir, pend_valid}); end
    endtask

    task automatic test_expiry;
        int lat, nmv, nq;
        logic [1:0] mdir, qd0;
        press(4'b0011);
        checks++; if ({pend_valid, pend_dir} !== 3'b110) begin errors++; $display("FAIL priority_left got %b exp 110", {pend_valid, pend_dir}); end
        walls = 4'b0100;
        for (int t = 1; t <= 8; t++) begin
            do_tick(lat, nmv, mdir, nq, qd0);
            if (t == 7) begin
                checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL expiry_tick7 got %b exp 1", pend_valid); end
            end
        end
        checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL expiry_tick8 got %b exp 0", pend_valid); end
        checks++; if (mdir !== 2'b00 || lat !== 4) begin errors++; $display("FAIL expiry_move got lat=%0d dir=%b exp lat=4 dir=00", lat, mdir); end
        do_tick(lat, nmv, mdir, nq, qd0);
        checks++; if (nq !== 1 || qd0 !== 2'b00 || lat !== 3) begin errors++; $display("FAIL expired_cur_only got n=%0d dir=%b lat=%0d exp n=1 dir=00 lat=3", nq, qd0, lat); end
        walls = 4'b0000;
    endtask

    task automatic test_press_during_query;
        int lat, nmv, nq, found;
        logic [1:0] mdir, qd0;
        press(4'b1000);
        ack_en = 1'b0;
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        checks++; if ({query_req, query_dir} !== 3'b100) begin errors++; $display("FAIL ask_pend_up got %b exp 100", {query_req, query_dir}); end
        left = 1'b1;
        @(negedge CLOCK_50);
        left = 1'b0;
        ack_en = 1'b1;
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            @(negedge CLOCK_50);
            if (move_valid) begin
                found = 1;
                checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL late_press_move got %b exp 00", move_dir); end
            end
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL late_press_timeout got %0d exp 1", found); end
        checks++; if ({pend_valid, pend_dir, cur_dir} !== 5'b11000) begin errors++; $display("FAIL late_press_regs got %b exp 11000", {pend_valid, pend_dir, cur_dir}); end
        do_tick(lat, nmv, mdir, nq, qd0);
        checks++; if (mdir !== 2'b10 || cur_dir !== 2'b10 || pend_valid !== 1'b0) begin errors++; $display("FAIL late_press_follow got dir=%b cur=%b pv=%b exp 10 10 0", mdir, cur_dir, pend_valid); end
    endtask

    task automatic test_overrun;
        int ov, mv;
        logic [1:0] md;
        ov = 0; mv = 0; md = 2'b00;
        ack_en = 1'b0;
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (overrun) ov++;
            if (move_valid) begin mv++; md = move_dir; end
            tick = (i == 2);
            ack_en = (i >= 6);
            @(negedge CLOCK_50);
        end
        tick = 1'b0;
        ack_en = 1'b1;
        checks++; if (ov !== 1) begin errors++; $display("FAIL overrun_count got %0d exp 1", ov); end
        checks++; if (mv !== 1 || md !== 2'b10) begin errors++; $display("FAIL overrun_moves got n=%0d dir=%b exp n=1 dir=10", mv, md); end
    endtask

    task automatic test_reset_mid_query;
        int lat, nmv, nq;
        logic [1:0] mdir, qd0;
        ack_en = 1'b0;
        tick = 1'b1;
        @(negedge CLOCK_50);
        tick = 1'b0;
        checks++; if ({query_req, query_dir} !== 3'b110) begin errors++; $display("FAIL ask_cur_req got %b exp 110", {query_req, query_dir}); end
        reset = 1'b1;
        up = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        up = 1'b0;
        checks++; if ({query_req, cur_valid, pend_valid} !== 3'b000) begin errors++; $display("FAIL mid_reset got %b exp 000", {query_req, cur_valid, pend_valid}); end
        ack_en = 1'b1;
        do_tick(lat, nmv, mdir, nq, qd0);
        checks++; if (nq !== 0 || nmv !== 0) begin errors++; $display("FAIL idle_tick got q=%0d m=%0d exp 0 0", nq, nmv); end
    endtask

    initial begin
        @(negedge CLOCK_50);
        test_reset;
        test_first_move;
        test_turn_retry;
        test_expiry;
        test_press_during_query;
        test_overrun;
        test_reset_mid_query;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter PEND_TICKS, default 8, ticks a blocked buffered turn is retained before it is discarded (range 1-255).
REQ-002 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 up, down, left, right  input  1 each  one-cycle direction-press pulses from the keyboard decoder.
REQ-005 tick  input  1  one-cycle game-step strobe.
REQ-006 query_req  output  1  wall-query request, held high until acknowledged.
REQ-007 query_dir  output  2  direction being queried: 00 up, 01 down, 10 left, 11 right.
REQ-008 query_ack  input  1  maze responder accepts the query; query_blocked is valid in the same cycle.
REQ-009 query_blocked  input  1  1 means a wall lies in query_dir from the current tile.
REQ-010 move_valid  output  1  one-cycle pulse commanding a one-tile step.
REQ-011 move_dir  output  2  step direction, valid with move_valid.
REQ-012 cur_valid, cur_dir  output  1, 2  current heading register.
REQ-013 pend_valid, pend_dir  output  1, 2  buffered turn register.
REQ-014 overrun  output  1  one-cycle pulse when a tick arrives while not in IDLE.

Function
REQ-015 Key capture, in any state: if any press pulse is high, load pend_dir with priority up > down > left > right, set pend_valid=1, and load the expiry counter with PEND_TICKS.
REQ-016 The FSM has four states: IDLE, ASK_PEND, ASK_CUR, MOVE.
REQ-017 IDLE on tick: go to ASK_PEND if pend_valid; else go to ASK_CUR if cur_valid; else stay in IDLE with no query issued.
REQ-018 On entering ASK_PEND or ASK_CUR, latch the query direction (pend_dir or cur_dir); query_dir holds the latched value and query_req=1 for every cycle in the state, including the ack cycle.
REQ-019 ASK_PEND with query_ack and !query_blocked: set cur_dir to the latched direction, set cur_valid=1, go to MOVE; clear pend_valid only if no key press was captured after the query was issued.
REQ-020 ASK_PEND with query_ack and query_blocked: decrement the expiry counter and clear pend_valid when it reaches 0; then go to ASK_CUR if cur_valid, else IDLE.
REQ-021 ASK_CUR with query_ack and !query_blocked: go to MOVE; with query_blocked: go to IDLE with cur_valid unchanged (stall against the wall).
REQ-022 MOVE lasts exactly one cycle: move_valid=1 with move_dir equal to the latched query direction; next state is IDLE.
REQ-023 Latency from tick to move_valid with zero-wait acks: 3 cycles via the pend path (ASK_PEND entered at tick+1); 3 cycles via the cur-only path; 4 cycles via pend-blocked then cur.
REQ-024 query_req is never high in IDLE or MOVE; a new query is issued at most once per tick.
REQ-025 A tick in any state other than IDLE is dropped: it does not queue, and overrun pulses in the following cycle.
REQ-026 query_blocked is ignored when query_ack=0; there is no timeout, so the FSM waits indefinitely.
REQ-027 A press while cur_valid=1 that matches cur_dir still loads pend (REQ-015); this is harmless.
REQ-028 Expiry counter is 8 bits and does not underflow; a counter already at 0 with pend_valid=1 cannot occur.

Reset
REQ-029 On a clock edge with reset=1: state=IDLE; query_req, move_valid, overrun, cur_valid, pend_valid = 0; cur_dir, pend_dir, move_dir, query_dir = 00; counter = 0.
REQ-030 Reset overrides everything, including a mid-query; query_req is low in the cycle after the reset edge, and a concurrent press pulse is discarded.

Verification
REQ-031 After reset, press right and tick; ack=1 with blocked=0 at the first ASK_PEND cycle -> move_valid at tick+3 with move_dir=11, cur_dir=11, pend_valid=0.
REQ-032 With cur_dir=11, press up; two ticks with up blocked and right open -> two moves with dir 11, pend_valid still 1; the third tick has up open -> move dir 00, cur_dir=00.
REQ-033 PEND_TICKS=2 with pend up blocked on every tick -> pend_valid=0 after the second tick; the third tick queries only cur_dir.
REQ-034 Press left during an ASK_PEND for up that gets ack with !blocked -> move 00; pend_valid=1 with pend_dir=10.
REQ-035 Delay ack by 5 cycles and pulse tick during the wait -> overrun pulses once, and only one move_valid results.
REQ-036 Assert reset in ASK_CUR with query_req=1 -> the next cycle shows query_req=0, cur_valid=0 and state IDLE; a tick with no press issues no query.
